// File: rtl/riscv_hazard_scoreboard_if.sv
// Hazard-unit signal bundle: EX forwarding, decode hazard inputs, long-latency
// writeback events, and the stall/scoreboard status returned by the unit.
interface riscv_hazard_scoreboard_if #(
  parameter int unsigned NUM_RS  = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 32
);
  localparam int unsigned SEL_W = $clog2(NUM_FWD + 1);

  logic [NUM_RS*5-1:0]     rs_e;
  logic [NUM_FWD*5-1:0]    fwd_rd;
  logic [NUM_FWD-1:0]      fwd_we;
  logic [NUM_RS*SEL_W-1:0] fwd_sel;
  logic [NUM_RS*5-1:0]     rs_d;
  logic [NUM_RS-1:0]       rs_used_d;
  logic [4:0]              rd_d;
  logic                    rd_we_d;
  logic                    load_e;
  logic [4:0]              rd_e;
  logic                    lat_issue;
  logic [4:0]              lat_issue_rd;
  logic                    lat_done;
  logic [4:0]              lat_done_rd;
  logic                    stall_d;
  logic                    bubble_e;
  logic [1:0]              stall_reason;
  logic [31:0]             sb_busy;
  logic                    sb_err;
  logic [CNT_W-1:0]        stall_cnt;

  // Pipeline side drives operands and events; the hazard unit returns controls.
  modport master (
    output rs_e, fwd_rd, fwd_we, rs_d, rs_used_d, rd_d, rd_we_d, load_e, rd_e,
           lat_issue, lat_issue_rd, lat_done, lat_done_rd,
    input  fwd_sel, stall_d, bubble_e, stall_reason, sb_busy, sb_err, stall_cnt
  );

  modport slave (
    input  rs_e, fwd_rd, fwd_we, rs_d, rs_used_d, rd_d, rd_we_d, load_e, rd_e,
           lat_issue, lat_issue_rd, lat_done, lat_done_rd,
    output fwd_sel, stall_d, bubble_e, stall_reason, sb_busy, sb_err, stall_cnt
  );
endinterface

// File: rtl/riscv_hazard_scoreboard.sv
// Hazard unit: nearest-stage operand forwarding, load-use detection and a
// per-register busy scoreboard for variable-latency writebacks, with stall counter.
module riscv_hazard_scoreboard #(
  parameter int unsigned NUM_RS  = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  riscv_hazard_scoreboard_if.slave  bus
);
  localparam int unsigned SEL_W = $clog2(NUM_FWD + 1);

  logic [31:0]             sb_busy_q, sb_busy_d;
  logic                    sb_err_q, sb_err_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;

  logic [NUM_RS*SEL_W-1:0] fwd_sel_c;
  logic                    load_use_c, raw_c, waw_c, stall_c;
  logic [1:0]              reason_c;
  logic [4:0]              rs_c;

  // Forwarding: scan farthest to nearest so the nearest matching stage wins.
  always_comb begin
    fwd_sel_c = '0;
    for (int i = 0; i < int'(NUM_RS); i++) begin
      for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
        if (bus.fwd_we[k] && (bus.fwd_rd[5*k +: 5] != 5'd0) &&
            (bus.fwd_rd[5*k +: 5] == bus.rs_e[5*i +: 5])) begin
          fwd_sel_c[SEL_W*i +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  // Decode-stage hazards; x0 is never busy so needs no special casing for RAW.
  always_comb begin
    load_use_c = 1'b0;
    raw_c      = 1'b0;
    rs_c       = 5'd0;
    for (int i = 0; i < int'(NUM_RS); i++) begin
      rs_c = bus.rs_d[5*i +: 5];
      if (bus.rs_used_d[i]) begin
        if (bus.load_e && (bus.rd_e != 5'd0) && (rs_c == bus.rd_e)) load_use_c = 1'b1;
        if (sb_busy_q[rs_c]) raw_c = 1'b1;
      end
    end
    waw_c   = bus.rd_we_d && (bus.rd_d != 5'd0) && sb_busy_q[bus.rd_d];
    stall_c = load_use_c | raw_c | waw_c;
    if (load_use_c)  reason_c = 2'b01;
    else if (raw_c)  reason_c = 2'b10;
    else if (waw_c)  reason_c = 2'b11;
    else             reason_c = 2'b00;
  end

  // Scoreboard next state: done clears, then issue sets so set wins on a tie.
  always_comb begin
    logic issue_v, done_v, same_v;
    issue_v   = bus.lat_issue && (bus.lat_issue_rd != 5'd0);
    done_v    = bus.lat_done && (bus.lat_done_rd != 5'd0);
    same_v    = issue_v && done_v && (bus.lat_issue_rd == bus.lat_done_rd);
    sb_busy_d = sb_busy_q;
    if (done_v)  sb_busy_d[bus.lat_done_rd]  = 1'b0;
    if (issue_v) sb_busy_d[bus.lat_issue_rd] = 1'b1;
    sb_busy_d[0] = 1'b0;
    sb_err_d = sb_err_q
             | (issue_v && sb_busy_q[bus.lat_issue_rd] && !same_v)
             | (done_v && !sb_busy_q[bus.lat_done_rd] && !same_v);
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_busy_q   <= '0;
      sb_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      sb_busy_q   <= sb_busy_d;
      sb_err_q    <= sb_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.fwd_sel      = fwd_sel_c;
  assign bus.stall_d      = stall_c;
  assign bus.bubble_e     = stall_c;
  assign bus.stall_reason = reason_c;
  assign bus.sb_busy      = sb_busy_q;
  assign bus.sb_err       = sb_err_q;
  assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Bench for riscv_hazard_scoreboard: fixed vector table, directed scoreboard
// sequences and random traffic against a set-based reference model.
module tb_riscv_hazard_scoreboard;
  logic clk;
  logic rst_n;

  riscv_hazard_scoreboard_if #(.NUM_RS(2), .NUM_FWD(2), .CNT_W(32)) bus ();
  riscv_hazard_scoreboard_if #(.NUM_RS(2), .NUM_FWD(2), .CNT_W(4))  bus_s ();

  riscv_hazard_scoreboard #(.NUM_RS(2), .NUM_FWD(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  riscv_hazard_scoreboard #(.NUM_RS(2), .NUM_FWD(2), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));

  assign bus_s.rs_e         = bus.rs_e;
  assign bus_s.fwd_rd       = bus.fwd_rd;
  assign bus_s.fwd_we       = bus.fwd_we;
  assign bus_s.rs_d         = bus.rs_d;
  assign bus_s.rs_used_d    = bus.rs_used_d;
  assign bus_s.rd_d         = bus.rd_d;
  assign bus_s.rd_we_d      = bus.rd_we_d;
  assign bus_s.load_e       = bus.load_e;
  assign bus_s.rd_e         = bus.rd_e;
  assign bus_s.lat_issue    = bus.lat_issue;
  assign bus_s.lat_issue_rd = bus.lat_issue_rd;
  assign bus_s.lat_done     = bus.lat_done;
  assign bus_s.lat_done_rd  = bus.lat_done_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: set of outstanding registers plus sticky error and counters.
  bit              pend[int];
  bit              ref_err;
  longint unsigned ref_cnt;
  int unsigned     ref_cnt_s;

  typedef struct {
    logic [9:0] rs_e;
    logic [9:0] fwd_rd;
    logic [1:0] fwd_we;
    logic [9:0] rs_d;
    logic [1:0] used;
    logic       load_e;
    logic [4:0] rd_e;
    logic [3:0] e_sel;
    logic       e_stall;
    logic [1:0] e_reason;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_busy();
    logic [31:0] v;
    v = '0;
    foreach (pend[r]) v[r] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] ref_fwd(input logic [9:0] rs, input logic [9:0] frd,
                                         input logic [1:0] we);
    logic [3:0] out;
    logic [9:0] rsv, frv;
    int sel;
    out = '0;
    rsv = rs;
    frv = frd;
    for (int i = 0; i < 2; i++) begin
      sel = 0;
      for (int k = 0; k < 2; k++)
        if (sel == 0 && we[k] && frv[5*k +: 5] != 5'd0 && frv[5*k +: 5] == rsv[5*i +: 5])
          sel = k + 1;
      out[2*i +: 2] = 2'(sel);
    end
    return out;
  endfunction

  task automatic idle();
    bus.rs_e = '0; bus.fwd_rd = '0; bus.fwd_we = '0;
    bus.rs_d = '0; bus.rs_used_d = '0; bus.rd_d = '0; bus.rd_we_d = 1'b0;
    bus.load_e = 1'b0; bus.rd_e = '0;
    bus.lat_issue = 1'b0; bus.lat_issue_rd = '0;
    bus.lat_done = 1'b0; bus.lat_done_rd = '0;
  endtask

  task automatic model_clear();
    pend.delete();
    ref_err = 1'b0;
    ref_cnt = 0;
    ref_cnt_s = 0;
  endtask

  // One clock: compare all outputs against the model, then advance the model.
  task automatic cycle();
    bit lu, raw, waw, st, iv, dv, same;
    logic [1:0] reason;
    logic [9:0] rsd;
    int ird, drd;
    #1;
    rsd = bus.rs_d;
    lu = 0; raw = 0;
    for (int i = 0; i < 2; i++) begin
      if (bus.rs_used_d[i]) begin
        if (bus.load_e && bus.rd_e != 0 && rsd[5*i +: 5] == bus.rd_e) lu = 1;
        if (pend.exists(int'(rsd[5*i +: 5]))) raw = 1;
      end
    end
    waw = bus.rd_we_d && bus.rd_d != 0 && pend.exists(int'(bus.rd_d));
    st = lu | raw | waw;
    reason = lu ? 2'b01 : raw ? 2'b10 : waw ? 2'b11 : 2'b00;
    chk("fwd_sel", 64'(bus.fwd_sel), 64'(ref_fwd(bus.rs_e, bus.fwd_rd, bus.fwd_we)));
    chk("stall_d", 64'(bus.stall_d), 64'(st));
    chk("bubble_e", 64'(bus.bubble_e), 64'(st));
    chk("stall_reason", 64'(bus.stall_reason), 64'(reason));
    chk("sb_busy", 64'(bus.sb_busy), 64'(ref_busy()));
    chk("sb_err", 64'(bus.sb_err), 64'(ref_err));
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(ref_cnt));
    chk("stall_cnt_sat4", 64'(bus_s.stall_cnt), 64'(ref_cnt_s));
    ird = int'(bus.lat_issue_rd);
    drd = int'(bus.lat_done_rd);
    iv = bus.lat_issue && ird != 0;
    dv = bus.lat_done && drd != 0;
    same = iv && dv && ird == drd;
    if (iv && pend.exists(ird) && !same) ref_err = 1;
    if (dv && !pend.exists(drd) && !same) ref_err = 1;
    if (dv) pend.delete(drd);
    if (iv) pend[ird] = 1'b1;
    if (st && ref_cnt != 64'hFFFF_FFFF) ref_cnt++;
    if (st && ref_cnt_s != 15) ref_cnt_s++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int keys[$];
    rst_n = 1'b0;
    idle();
    model_clear();
    vt[0]  = '{10'({5'd5, 5'd5}), 10'({5'd5, 5'd5}), 2'b11, 10'd0, 2'b00, 1'b0, 5'd0, 4'b0101, 1'b0, 2'b00};
    vt[1]  = '{10'({5'd5, 5'd5}), 10'({5'd5, 5'd0}), 2'b11, 10'd0, 2'b00, 1'b0, 5'd0, 4'b1010, 1'b0, 2'b00};
    vt[2]  = '{10'd0, 10'd0, 2'b11, 10'd0, 2'b00, 1'b0, 5'd0, 4'b0000, 1'b0, 2'b00};
    vt[3]  = '{10'({5'd3, 5'd6}), 10'({5'd3, 5'd6}), 2'b11, 10'd0, 2'b00, 1'b0, 5'd0, 4'b1001, 1'b0, 2'b00};
    vt[4]  = '{10'({5'd6, 5'd6}), 10'({5'd6, 5'd6}), 2'b01, 10'd0, 2'b00, 1'b0, 5'd0, 4'b0101, 1'b0, 2'b00};
    vt[5]  = '{10'({5'd6, 5'd6}), 10'({5'd6, 5'd6}), 2'b10, 10'd0, 2'b00, 1'b0, 5'd0, 4'b1010, 1'b0, 2'b00};
    vt[6]  = '{10'({5'd6, 5'd6}), 10'({5'd6, 5'd6}), 2'b00, 10'd0, 2'b00, 1'b0, 5'd0, 4'b0000, 1'b0, 2'b00};
    vt[7]  = '{10'd0, 10'd0, 2'b00, 10'({5'd0, 5'd7}), 2'b01, 1'b1, 5'd7, 4'b0000, 1'b1, 2'b01};
    vt[8]  = '{10'd0, 10'd0, 2'b00, 10'({5'd0, 5'd7}), 2'b00, 1'b1, 5'd7, 4'b0000, 1'b0, 2'b00};
    vt[9]  = '{10'd0, 10'd0, 2'b00, 10'({5'd7, 5'd0}), 2'b10, 1'b1, 5'd7, 4'b0000, 1'b1, 2'b01};
    vt[10] = '{10'd0, 10'd0, 2'b00, 10'd0, 2'b11, 1'b1, 5'd0, 4'b0000, 1'b0, 2'b00};
    vt[11] = '{10'd0, 10'd0, 2'b00, 10'({5'd7, 5'd7}), 2'b11, 1'b0, 5'd7, 4'b0000, 1'b0, 2'b00};

    repeat (2) @(negedge clk);
    chk("reset_sb_busy", 64'(bus.sb_busy), 64'd0);
    chk("reset_sb_err", 64'(bus.sb_err), 64'd0);
    chk("reset_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    rst_n = 1'b1;

    // Table vectors with an empty scoreboard.
    for (int v = 0; v < 12; v++) begin
      idle();
      bus.rs_e = vt[v].rs_e; bus.fwd_rd = vt[v].fwd_rd; bus.fwd_we = vt[v].fwd_we;
      bus.rs_d = vt[v].rs_d; bus.rs_used_d = vt[v].used;
      bus.load_e = vt[v].load_e; bus.rd_e = vt[v].rd_e;
      #1;
      chk($sformatf("vec%0d_fwd_sel", v), 64'(bus.fwd_sel), 64'(vt[v].e_sel));
      chk($sformatf("vec%0d_stall", v), 64'(bus.stall_d), 64'(vt[v].e_stall));
      chk($sformatf("vec%0d_reason", v), 64'(bus.stall_reason), 64'(vt[v].e_reason));
      cycle();
    end

    // Long-latency op on x9 stalls a dependent decode for five cycles.
    idle(); do_reset();
    bus.lat_issue = 1'b1; bus.lat_issue_rd = 5'd9;
    cycle();
    idle();
    bus.rs_d = 10'({5'd9, 5'd0}); bus.rs_used_d = 2'b10;
    for (int j = 1; j <= 5; j++) begin
      bus.lat_done = (j == 5); bus.lat_done_rd = 5'd9;
      #1;
      chk("sb_raw_reason", 64'(bus.stall_reason), 64'd2);
      chk("sb_busy9_set", 64'(bus.sb_busy[9]), 64'd1);
      cycle();
    end
    idle();
    #1;
    chk("sb_busy9_clear", 64'(bus.sb_busy[9]), 64'd0);
    chk("sb_stall_cnt5", 64'(bus.stall_cnt), 64'd5);
    cycle();

    // WAW, RAW-over-WAW priority, set-wins and error cases.
    idle(); do_reset();
    bus.lat_issue = 1'b1; bus.lat_issue_rd = 5'd3;
    cycle();
    idle(); bus.rd_d = 5'd3; bus.rd_we_d = 1'b1;
    #1; chk("waw_reason", 64'(bus.stall_reason), 64'd3);
    cycle();
    bus.rs_d = 10'({5'd0, 5'd3}); bus.rs_used_d = 2'b01;
    #1; chk("raw_over_waw", 64'(bus.stall_reason), 64'd2);
    cycle();
    idle(); bus.lat_issue = 1'b1; bus.lat_issue_rd = 5'd3;
    bus.lat_done = 1'b1; bus.lat_done_rd = 5'd3;
    cycle();
    idle(); #1;
    chk("setwins_busy3", 64'(bus.sb_busy[3]), 64'd1);
    chk("setwins_no_err", 64'(bus.sb_err), 64'd0);
    bus.lat_done = 1'b1; bus.lat_done_rd = 5'd0;
    bus.lat_issue = 1'b1; bus.lat_issue_rd = 5'd0;
    cycle();
    idle(); #1;
    chk("x0_ignored_err", 64'(bus.sb_err), 64'd0);
    chk("x0_ignored_busy", 64'(bus.sb_busy), 64'h8);
    bus.lat_done = 1'b1; bus.lat_done_rd = 5'd4;
    cycle();
    idle(); cycle(); cycle();
    chk("err_sticky", 64'(bus.sb_err), 64'd1);
    do_reset();
    bus.lat_issue = 1'b1; bus.lat_issue_rd = 5'd3;
    cycle(); cycle();
    idle(); #1;
    chk("err_double_issue", 64'(bus.sb_err), 64'd1);

    // Asynchronous reset mid-stall with x9/x12 outstanding.
    do_reset();
    bus.lat_issue = 1'b1; bus.lat_issue_rd = 5'd9; cycle();
    bus.lat_issue_rd = 5'd12; cycle();
    idle(); bus.load_e = 1'b1; bus.rd_e = 5'd7; bus.rs_d = 10'd7; bus.rs_used_d = 2'b01;
    repeat (40) cycle();
    chk("pre_rst_cnt40", 64'(bus.stall_cnt), 64'd40);
    chk("pre_rst_busy", 64'(bus.sb_busy), 64'h1200);
    chk("sat4_cnt", 64'(bus_s.stall_cnt), 64'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(bus.sb_busy), 64'd0);
    chk("async_rst_err", 64'(bus.sb_err), 64'd0);
    chk("async_rst_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst_load_stall", 64'(bus.stall_d), 64'd1);
    bus.load_e = 1'b0; #1;
    chk("rst_no_stall", 64'(bus.stall_d), 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      bus.rs_e = 10'({5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))});
      bus.fwd_rd = 10'({5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))});
      bus.fwd_we = 2'($urandom);
      bus.rs_d = 10'({5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))});
      bus.rs_used_d = 2'($urandom);
      bus.rd_d = 5'($urandom_range(0, 15));
      bus.rd_we_d = 1'($urandom);
      bus.load_e = ($urandom_range(0, 3) == 0);
      bus.rd_e = 5'($urandom_range(0, 15));
      bus.lat_issue = ($urandom_range(0, 3) == 0);
      bus.lat_issue_rd = 5'($urandom_range(0, 15));
      keys = {};
      foreach (pend[r]) keys.push_back(r);
      bus.lat_done = 1'b0;
      bus.lat_done_rd = 5'($urandom_range(0, 15));
      if (keys.size() > 0 && $urandom_range(0, 2) == 0) begin
        bus.lat_done = 1'b1;
        bus.lat_done_rd = 5'(keys[$urandom_range(0, keys.size() - 1)]);
      end else if ($urandom_range(0, 99) == 0) begin
        bus.lat_done = 1'b1;
      end
      if (c == 1000) begin
        idle(); do_reset();
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_hazard_scoreboard.md
Name: riscv_hazard_scoreboard

Overview:
- Parametrised hazard unit for the RISC-V core pipeline.
- Generalises EX-stage operand forwarding to NUM_RS source ports and NUM_FWD stages, with nearest stage winning.
- Detects load-use hazards and tracks outstanding variable-latency writebacks (DIV, accelerator ops) in a per-register busy scoreboard.
- Issues stall/bubble controls to decode and keeps a saturating stall-cycle counter; sits beside the decode/execute pipeline registers.

Parameters:
- NUM_RS, 2: source operand ports per instruction (rs1, rs2, optionally rs3).
- NUM_FWD, 2: forwarding stages; index 0 = nearest (MEM), NUM_FWD-1 = farthest (WB).
- SEL_W, $clog2(NUM_FWD+1): width of each forward select (derived, do not override).
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rs_e  in  NUM_RS*5  EX-stage source regs; port i at [5i+:5]
- fwd_rd  in  NUM_FWD*5  destination reg of each forwarding stage
- fwd_we  in  NUM_FWD  register-write enable of each forwarding stage
- fwd_sel  out  NUM_RS*SEL_W  per-port select: 0 = regfile, k = stage k-1
- rs_d  in  NUM_RS*5  decode-stage source regs
- rs_used_d  in  NUM_RS  decode source port actually read
- rd_d  in  5  decode destination reg
- rd_we_d  in  1  decode instruction writes rd
- load_e  in  1  EX-stage instruction is a load
- rd_e  in  5  EX-stage destination reg
- lat_issue  in  1  long-latency op leaves EX this cycle
- lat_issue_rd  in  5  its destination reg
- lat_done  in  1  long-latency result written back this cycle
- lat_done_rd  in  5  its destination reg
- stall_d  out  1  hold PC/IF/ID registers
- bubble_e  out  1  insert NOP into ID/EX
- stall_reason  out  2  00 none, 01 load-use, 10 scoreboard RAW, 11 scoreboard WAW
- sb_busy  out  32  scoreboard busy vector; bit 0 always 0
- sb_err  out  1  sticky protocol error
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Forwarding (combinational, per port i):
  - fwd_sel = lowest k+1 such that fwd_we[k], fwd_rd[k]!=0 and fwd_rd[k]==rs_e[i]; otherwise 0.
  - Register x0 is never forwarded.
- Load-use hazard: load_e && rd_e!=0 && any used port i with rs_d[i]==rd_e.
- Scoreboard RAW: any used port i with sb_busy[rs_d[i]].
- Scoreboard WAW: rd_we_d && rd_d!=0 && sb_busy[rd_d].
- Any hazard asserts stall_d=bubble_e=1, combinationally, same cycle.
- stall_reason priority when several hazards hold: load-use > RAW > WAW.
- Scoreboard (registered, updates on posedge clk):
  - lat_issue with rd!=0 sets the busy bit for that reg.
  - lat_done clears the busy bit for that reg.
  - Issue and done on the same reg in the same cycle: set wins (new op outstanding).
  - Issue and done on different regs in the same cycle: both apply.
  - Bit 0 is hardwired 0; issue/done to x0 is ignored.
- sb_err (sticky until reset):
  - set by lat_issue to an already-busy reg;
  - set by lat_done to a non-busy reg, except when it is the same-cycle set-wins case.
  - Busy bit state is still updated per the rules above.
- stall_cnt increments each cycle stall_d=1; saturates at all-ones, no wrap.
- Pipeline flushes do not clear scoreboard bits; issued ops always complete.
- Reset (asynchronous, any time including mid-stall):
  - sb_busy=0, sb_err=0, stall_cnt=0.
  - Combinational outputs follow their inputs; stall_d is 0 while no load hazard.
- All outputs are defined (no X) for any input combination when rst_n=1.

Test Plan:
- fwd_we=2'b11, fwd_rd={5,5}, rs_e={5,5} → both fwd_sel=1 (MEM beats WB); set fwd_rd[0]=0 → both fwd_sel=2.
- Decode then x0: rs_e={0,0}, fwd_we=2'b11, fwd_rd={0,0} → fwd_sel=0.
- Load-use: load_e=1, rd_e=7, rs_d[0]=7, rs_used_d=01 → stall_d=bubble_e=1, reason=01. With rs_used_d=00 → no stall.
- Scoreboard: lat_issue rd=9 at cycle t → sb_busy[9]=1 from t+1; rs_d[1]=9 used → reason=10, stall each cycle. lat_done rd=9 at t+5 → busy clears at t+6; stall_cnt=5.
- Simultaneous/errors:
  - issue rd=3 and done rd=3 in the same cycle with bit set → bit stays 1, sb_err=0;
  - done rd=4 while idle → sb_err=1 and stays 1;
  - issue rd=3 while busy → sb_err=1.
- Reset mid-operation: busy={9,12}, stall_cnt=40, rst_n low asynchronously between edges → all registered outputs 0 immediately. Preload stall_cnt near max by force → saturates at 0xFFFFFFFF.
